// File: rtl/ss_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Uses a framed shadow register so a new value only appears at a frame start.
module ss_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DRIVE_CYC  = 1000,
  parameter int GAP_CYC    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [3:0]              nib_out,
  output logic                    dec_en,
  output logic                    frame_tick
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (DRIVE_CYC > GAP_CYC) ? DRIVE_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    OFF,
    DRIVE,
    GAP
  } state_t;

  state_t                  state_q, state_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [IW-1:0]           idx_q, idx_n;
  logic [4*NUM_DIGITS-1:0] pend_q;
  logic                    pend_vld_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic                    lz_q;
  logic                    frame_ld;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    frame_ld = 1'b0;
    if (!run) begin
      state_n = OFF;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_n  = DRIVE;
          cnt_n    = '0;
          idx_n    = '0;
          frame_ld = 1'b1;
        end
        DRIVE: begin
          if (cnt_q == CW'(DRIVE_CYC - 1)) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == CW'(GAP_CYC - 1)) begin
            state_n = DRIVE;
            cnt_n   = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
              idx_n    = '0;
              frame_ld = 1'b1;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        default: state_n = OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      shadow_q   <= '0;
      lz_q       <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      lz_q    <= lz_en;
      if (frame_ld && pend_vld_q)
        shadow_q <= pend_q;
      // a load coinciding with the frame load stays pending
      if (load) begin
        pend_q     <= digits_in;
        pend_vld_q <= 1'b1;
      end else if (frame_ld && pend_vld_q) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  logic [NUM_DIGITS-1:0] sup;
  logic                  allz;

  always_comb begin
    sup  = '0;
    allz = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      allz   = allz & (shadow_q[4*i +: 4] == 4'h0);
      sup[i] = lz_q & allz;
    end
  end

  logic                  drv;
  logic [NUM_DIGITS-1:0] sel_one;

  assign drv        = (state_q == DRIVE);
  assign sel_one    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  assign dig_sel    = drv ? (sel_one << idx_q) : '0;
  assign nib_out    = drv ? shadow_q[4*idx_q +: 4] : 4'h0;
  assign dec_en     = drv & ~sup[idx_q];
  assign frame_tick = drv && (idx_q == '0) && (cnt_q == '0);

endmodule
